// File: rtl/axil_elastic_buffer.sv
// Multi-entry valid/ready elastic buffer with registered in_ready, optional
// registered output stage, occupancy level, almost-full flag and synchronous flush.
module axil_elastic_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 4,
  parameter int REGISTER_OUTPUT   = 1,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(ALMOST_FULL_LEVEL);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [LVL_W-1:0]      level_r;
  logic [LVL_W-1:0]      level_nxt_s;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  almost_full_r;
  logic                  push_s;
  logic                  pop_s;

  // Flush must block a push in its own cycle, so it gates the registered ready.
  assign in_ready    = in_ready_r & ~flush;
  assign push_s      = in_valid & in_ready;
  assign pop_s       = out_valid_r & out_ready;
  assign out_valid   = out_valid_r;
  assign level       = level_r;
  assign almost_full = almost_full_r;

  // Next occupancy from the two handshakes.
  always_comb begin
    level_nxt_s = level_r;
    if (push_s && !pop_s) begin
      level_nxt_s = level_r + LVL_ONE;
    end else if (!push_s && pop_s) begin
      level_nxt_s = level_r - LVL_ONE;
    end else begin
      level_nxt_s = level_r;
    end
  end

  // Pointers, occupancy and the registered status flags derived from it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r      <= PTR_ZERO;
      rd_ptr_r      <= PTR_ZERO;
      level_r       <= LVL_ZERO;
      out_valid_r   <= 1'b0;
      in_ready_r    <= 1'b1;
      almost_full_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r       <= level_nxt_s;
      out_valid_r   <= (level_nxt_s != LVL_ZERO);
      in_ready_r    <= (level_nxt_s < LVL_FULL);
      almost_full_r <= (level_nxt_s >= LVL_AF);
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  generate
    if (REGISTER_OUTPUT != 0) begin : gen_reg_out
      logic [DATA_WIDTH-1:0] out_data_r;
      logic [PTR_W-1:0]      rd_ptr_inc_s;

      assign rd_ptr_inc_s = rd_ptr_r + PTR_ONE;
      assign out_data     = out_data_r;

      // Head register: an empty buffer (or one whose only entry is leaving)
      // takes the incoming word; otherwise it takes the entry behind the head.
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          out_data_r <= {DATA_WIDTH{1'b0}};
        end else if ((level_r == LVL_ZERO) || (pop_s && (level_r == LVL_ONE))) begin
          if (push_s) begin
            out_data_r <= in_data;
          end
        end else if (pop_s) begin
          out_data_r <= mem_r[rd_ptr_inc_s];
        end
      end
    end else begin : gen_mux_out
      assign out_data = mem_r[rd_ptr_r];
    end
  endgenerate

endmodule

// File: tb/tb_axil_elastic_buffer.sv
// Scoreboard bench for axil_elastic_buffer: three configurations share stimulus,
// the active one is checked against a queue model every cycle.
module tb_axil_elastic_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        ir0, ir1, ir2, ov0, ov1, ov2, af0, af1, af2;
  logic [31:0] od0, od1, od2;
  logic [2:0]  lv0, lv1;
  logic [1:0]  lv2;

  logic        c_ir, c_ov, c_af;
  logic [31:0] c_od;
  logic [2:0]  c_lv;

  int          cur, dep, afl;
  int          total, bad, pops, acc;
  logic        mon_en;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  axil_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .REGISTER_OUTPUT(1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .level(lv0), .almost_full(af0));

  axil_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .REGISTER_OUTPUT(0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .level(lv1), .almost_full(af1));

  axil_elastic_buffer #(.DATA_WIDTH(32), .DEPTH(2), .REGISTER_OUTPUT(0)) dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
    .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
    .level(lv2), .almost_full(af2));

  // Route the configuration under test to the checkers.
  always_comb begin
    case (cur)
      0: begin c_ir = ir0; c_ov = ov0; c_af = af0; c_od = od0; c_lv = lv0; end
      1: begin c_ir = ir1; c_ov = ov1; c_af = af1; c_od = od1; c_lv = lv1; end
      default: begin c_ir = ir2; c_ov = ov2; c_af = af2; c_od = od2; c_lv = {1'b0, lv2}; end
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cfg=%0d t=%0t got=%h expected=%h", nm, cur, $time, act, expv);
    end
  endtask

  // Monitor: compare outputs with the model, then advance the model by this edge.
  always @(negedge clk) begin
    if (mon_en) begin
      int qs;
      qs = exp_q.size();
      chk("level", c_lv, qs);
      chk("out_valid", c_ov, qs != 0);
      chk("in_ready", c_ir, !flush && (qs < dep));
      chk("almost_full", c_af, qs >= afl);
      if (qs != 0) chk("out_data", c_od, exp_q[0]);
      if (rst || flush) begin
        exp_q.delete();
      end else begin
        if (qs != 0 && out_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
        if (in_valid && qs < dep) begin
          exp_q.push_back(in_data);
          acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input logic [31:0] base, input int n, input int budget);
    int sent = 0;
    int cyc = 0;
    int a0;
    in_valid = 1'b1;
    while (sent < n && cyc < budget) begin
      in_data = base + sent;
      a0 = acc;
      tick();
      if (acc != a0) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_budget", sent, n);
  endtask

  task automatic run_cfg(input int k);
    int lvl;
    mon_en = 1'b0;
    exp_q.delete();
    cur = k;
    dep = (k == 2) ? 2 : 4;
    afl = dep - 1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = 32'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("rst_level", c_lv, 0);
    chk("rst_in_ready", c_ir, 1);
    chk("rst_out_valid", c_ov, 0);
    chk("rst_almost_full", c_af, 0);
    if (k == 0) chk("rst_out_data", c_od, 32'h0);

    // single word, no backpressure
    pops = 0;
    out_ready = 1'b1;
    stream(32'hCAFECABE, 1, 10);
    repeat (3) tick();
    chk("s1_pops", pops, 1);
    chk("s1_level", c_lv, 0);

    // fill with consumer stalled
    out_ready = 1'b0;
    stream(32'hDEADCAFE, dep, 20);
    tick();
    chk("s2_level", c_lv, dep);
    chk("s2_in_ready", c_ir, 0);
    chk("s2_almost_full", c_af, 1);
    chk("s2_out_data", c_od, 32'hDEADCAFE);

    // drain from full while the producer keeps offering
    pops = 0;
    out_ready = 1'b1;
    stream(32'hDEADCAFE + dep, 100 - dep, 400);
    repeat (dep + 2) tick();
    chk("s3_pops", pops, 100);

    // steady push and pop at a partial level
    lvl = (dep > 2) ? 2 : 1;
    out_ready = 1'b0;
    stream(32'h0000_1000, lvl, 20);
    out_ready = 1'b1;
    stream(32'h0000_2000, 6, 30);
    chk("s4_level", c_lv, lvl);
    repeat (dep + 2) tick();

    // flush with the producer still valid
    out_ready = 1'b0;
    stream(32'h0000_3000, dep - 1, 20);
    in_valid = 1'b1;
    in_data = 32'hBAD0BAD0;
    flush = 1'b1;
    #1;
    chk("s5_in_ready", c_ir, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("s5_level", c_lv, 0);
    chk("s5_out_valid", c_ov, 0);
    chk("s5_almost_full", c_af, 0);
    pops = 0;
    out_ready = 1'b1;
    stream(32'h12345678, 1, 10);
    repeat (2) tick();
    chk("s5_pops", pops, 1);

    // reset while the consumer is ready
    out_ready = 1'b0;
    stream(32'h0000_4000, dep - 1, 20);
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s6_level", c_lv, 0);
    chk("s6_out_valid", c_ov, 0);
    chk("s6_in_ready", c_ir, 1);
    chk("s6_almost_full", c_af, 0);
    if (k == 0) chk("s6_out_data", c_od, 32'h0);
    repeat (2) tick();
  endtask

  initial begin
    total = 0; bad = 0; pops = 0; acc = 0;
    mon_en = 1'b0;
    cur = 0; dep = 4; afl = 3;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h0;
    for (int k = 0; k < 3; k++) run_cfg(k);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_elastic_buffer.md
Name: axil_elastic_buffer

Overview:
- Parametrised multi-entry successor to the single-slot AXI-lite skid buffer.
- Decouples a valid/ready producer from a valid/ready consumer using DEPTH entries of storage.
- in_ready is registered, so no combinational path runs from out_ready to in_ready.
- Adds an optional registered output stage, an occupancy level, an almost-full flag and a synchronous flush; sits on AXI-lite AW/W/B/AR/R channels and on internal streaming links.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, number of storage entries; power of two, 2 to 64.
- REGISTER_OUTPUT, 1. 1: out_data/out_valid are driven directly from flops. 0: out_data is muxed from storage at the read pointer.
- ALMOST_FULL_LEVEL, DEPTH-1, occupancy at which almost_full asserts (1 to DEPTH).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous discard of all contents.
- in_valid  in  1  producer data valid.
- in_ready  out  1  buffer can accept; registered.
- in_data  in  DATA_WIDTH  producer payload.
- out_valid  out  1  buffer holds data for the consumer.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH  consumer payload.
- level  out  $clog2(DEPTH+1)  current occupancy, 0 to DEPTH.
- almost_full  out  1  high when level >= ALMOST_FULL_LEVEL.

Behaviour:
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Transfers happen on the rising edge where the handshake is true.
- Reset (rst=1 at an edge) sets:
  - write and read pointers = 0, level = 0;
  - out_valid = 0, in_ready = 1, almost_full = 0;
  - out_data = 0 when REGISTER_OUTPUT=1;
  - storage contents are not reset.
- Reset mid-operation: all held data is lost; no pop occurs in the reset cycle even if out_ready=1.
- Flush:
  - flush=1 at an edge behaves as reset for pointers, level, out_valid and almost_full.
  - in_ready is combinationally forced to 0 while flush=1, so nothing is pushed in a flush cycle.
  - A concurrent pop is treated as lost.
  - rst has priority over flush.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- in_ready next = (level_next < DEPTH).
  - When full with pop=1, in_ready rises on the following cycle.
  - Push in the same cycle as that pop is impossible; this is intended, because the ready path is fully registered.
- Latency: data pushed at edge N is visible on out_data with out_valid=1 after edge N when the buffer was empty. This is 1 cycle in both REGISTER_OUTPUT modes.
- REGISTER_OUTPUT=1:
  - Holds the head entry in an output register.
  - On pop, the register loads the next entry or, if the buffer was empty apart from the head, the same-cycle push.
  - out_data is stable while out_valid=1 and out_ready=0.
- REGISTER_OUTPUT=0: out_data = mem[rd_ptr], valid only when out_valid=1.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are decided from level, never from pointer equality.
- Ordering: strict FIFO; no entry is duplicated or dropped except by rst/flush.
- AXI rules:
  - out_valid never deasserts without a pop, rst or flush.
  - in_valid deasserting without a push is tolerated (no state change).
- almost_full: registered, consistent with level on the same cycle.

Test Plan:
- No backpressure: hold out_ready=1, push 0xCAFECABE for 1 cycle → out_valid=1 for exactly 1 cycle, out_data=0xCAFECABE, level returns to 0, in_ready stays 1.
- Fill and stall: out_ready=0, push 0xDEADCAFE+i for i=0..DEPTH-1 → level=DEPTH, in_ready=0, almost_full=1 from level 3 (DEPTH=4), out_data=0xDEADCAFE held stable.
- Drain from full: out_ready=1 with in_valid held → next cycle in_ready=1; outputs appear in order 0xDEADCAFE..0xDEADCB01 followed by new data; no loss or duplicates over 100 transfers.
- Simultaneous push/pop at level 2 → level stays 2; out_data sequence stays in order.
- Flush at level 3 with in_valid=1 → in_ready=0 that cycle; next cycle level=0, out_valid=0, almost_full=0; next push 0x12345678 emerges first.
- Reset mid-stream with out_ready=1 → no pop counted, all outputs at reset values next cycle; repeat every scenario with REGISTER_OUTPUT=0 and DEPTH=2.
